// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the RAM arbiter: state encoding, port ids, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int DEFAULT_NPORTS = 3;
    localparam int DEFAULT_AW     = 16;
    localparam int DEFAULT_DW     = 16;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DATA  = 1;
    localparam int PORT_DMA   = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ACCESS,
        ST_DONE
    } state_t;

    // Index width that stays legal for a single-port build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational picker: first set req bit searching upward from base, wrapping.
// Latency: 0 cycles.
// Backpressure: none; base tied to 0 gives lowest-index fixed priority.
module arb_picker
    import mem_arbiter_pkg::*;
#(
    parameter int NPORTS = DEFAULT_NPORTS
) (
    input  logic [NPORTS-1:0]        req,
    input  logic [idx_w(NPORTS)-1:0] base,
    output logic                     valid,
    output logic [idx_w(NPORTS)-1:0] idx
);
    localparam int IW = idx_w(NPORTS);

    always_comb begin
        int p;
        valid = 1'b0;
        idx   = '0;
        p     = 0;
        for (int i = 0; i < NPORTS; i++) begin
            p = (int'(base) + i) % NPORTS;
            if (!valid && req[IW'(p)]) begin
                valid = 1'b1;
                idx   = IW'(p);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter/sequencer in front of the 64Kx16 ram; MEM_ARBITER_RR_EN selects round-robin.
// Latency: req seen in IDLE -> ack/rdata 3 cycles later; one access per 4 cycles.
// Backpressure: requesters hold req until their one-cycle ack; losers simply stay pending.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NPORTS = DEFAULT_NPORTS,
    parameter int AW     = DEFAULT_AW,
    parameter int DW     = DEFAULT_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    req_we,
    input  logic [NPORTS-1:0]    req_ind,
    input  logic [NPORTS*AW-1:0] req_addr,
    input  logic [NPORTS*DW-1:0] req_wdata,
    output logic [NPORTS-1:0]    ack,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic                 ram_we,
    output logic                 ram_ptr,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata
);
    localparam int IW = idx_w(NPORTS);

    state_t        state, state_n;
    logic [IW-1:0] win_q;
    logic          we_q;
    logic [IW-1:0] pick_base;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          grant_go;

    logic [AW-1:0] addr_arr  [NPORTS];
    logic [DW-1:0] wdata_arr [NPORTS];

    for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    arb_picker #(.NPORTS(NPORTS)) u_picker (
        .req   (req),
        .base  (pick_base),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign grant_go = (state == ST_IDLE) && pick_vld;

`ifdef MEM_ARBITER_RR_EN
    logic [IW-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= IW'(NPORTS - 1);
        end else if (grant_go) begin
            rr_ptr <= pick_idx;
        end
    end

    assign pick_base = (rr_ptr == IW'(NPORTS - 1)) ? '0 : rr_ptr + 1'b1;
`else
    assign pick_base = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (pick_vld) state_n = ST_GRANT;
            ST_GRANT:  state_n = ST_ACCESS;
            ST_ACCESS: state_n = ST_DONE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so ram_we is stable across the falling edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_q     <= '0;
            we_q      <= 1'b0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            ram_we    <= 1'b0;
            ram_ptr   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            busy   <= (state_n == ST_GRANT) || (state_n == ST_ACCESS);
            ram_we <= (state_n == ST_ACCESS) && we_q;
            ack    <= '0;
            if (grant_go) begin
                win_q     <= pick_idx;
                we_q      <= req_we[pick_idx];
                ram_ptr   <= req_ind[pick_idx];
                ram_addr  <= addr_arr[pick_idx];
                ram_wdata <= wdata_arr[pick_idx];
            end
            if (state == ST_ACCESS) begin
                rdata <= we_q ? ram_wdata : ram_rdata;
                ack   <= NPORTS'(1) << win_q;
            end
        end
    end

endmodule
